// File: rtl/ternary_prog_loader_pkg.sv
// Shared definitions for the ternary program loader: trit encodings,
// frame constants, error codes and the loader state encoding.
package ternary_prog_loader_pkg;

    // Two-bit trit encoding used on the program-load port
    localparam logic [1:0] TRIT_Z   = 2'b00;
    localparam logic [1:0] TRIT_P   = 2'b01;
    localparam logic [1:0] TRIT_N   = 2'b10;
    localparam logic [1:0] TRIT_INV = 2'b11;

    // Frame defaults
    localparam int         DEF_IMEM_DEPTH = 243;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

    // Word geometry
    localparam int WORD_TRITS = 9;
    localparam int WORD_BITS  = 2 * WORD_TRITS;

    // Reason the last frame was rejected
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_TRIT  = 2'd2,
        ERR_CHK   = 2'd3
    } err_code_e;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_ADDR = 3'd1,
        ST_HDR_CNT  = 3'd2,
        ST_DATA     = 3'd3,
        ST_WRITE    = 3'd4,
        ST_CHK      = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } loader_state_e;

    // A trit is usable when it is one of the three legal codes
    function automatic logic trit_ok(input logic [1:0] t);
        return (t != TRIT_INV) && ((t == TRIT_Z) || (t == TRIT_P) || (t == TRIT_N));
    endfunction

endpackage

// File: rtl/ternary_word_check.sv
// Assembles one 9-trit instruction word from its three transfer bytes and
// flags whether it is well formed (pad bits clear, no invalid trit code).
module ternary_word_check
    import ternary_prog_loader_pkg::*;
(
    input  logic [7:0]           b0,
    input  logic [7:0]           b1,
    input  logic [7:0]           b2,
    output logic [WORD_BITS-1:0] word,
    output logic                 valid
);

    // Concatenate bytes into the word and scan every trit for the 11 code
    always_comb begin
        word  = {b0[1:0], b1, b2};
        valid = (b0[7:2] == 6'd0);
        for (int i = 0; i < WORD_TRITS; i++) begin
            if (!trit_ok(word[2*i +: 2])) begin
                valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ternary_prog_loader.sv
// Byte-stream boot loader for the ternary CPU system. Parses a framed image
// (SYNC, START, COUNT, COUNT x 3-byte words, CHK), writes each word into
// instruction memory through the program-load port and releases the CPU
// from reset only after a frame completes with a good checksum.
//
// Handshake: a byte moves from host to loader on a rising edge where both
// in_valid and in_ready are 1. The host holds in_data stable while in_valid
// is high and not yet accepted; in_ready does not depend on in_valid.
module ternary_prog_loader
    import ternary_prog_loader_pkg::*;
#(
    parameter int         IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 prog_mode,
    output logic [7:0]           prog_addr,
    output logic [WORD_BITS-1:0] prog_data,
    output logic                 prog_we,
    output logic                 cpu_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [2:0]           dbg_state
);

    loader_state_e state;

    logic [7:0] addr_cnt;     // next instruction address to write
    logic [7:0] remain_cnt;   // words still to be received
    logic [1:0] byte_idx;     // position within the current 3-byte word
    logic [7:0] b0_q;
    logic [7:0] b1_q;
    logic [7:0] csum;         // running sum of START onward

    logic                 accept;
    logic [7:0]           csum_next;
    logic [8:0]           end_addr;
    logic                 range_bad;
    logic [WORD_BITS-1:0] word;
    logic                 word_valid;

    assign accept    = in_valid && in_ready;
    assign csum_next = csum + in_data;
    assign dbg_state = state;

    // START + COUNT is compared in 9 bits so a large start cannot wrap past the check
    assign end_addr  = {1'b0, addr_cnt} + {1'b0, in_data};
    assign range_bad = (in_data == 8'd0) || (end_addr > 9'(IMEM_DEPTH));

    // The third byte is taken straight from the bus so the write can be issued on the accepting edge
    ternary_word_check u_word_check (
        .b0    (b0_q),
        .b1    (b1_q),
        .b2    (in_data),
        .word  (word),
        .valid (word_valid)
    );

    // Frame parser, counters, checksum and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_cnt   <= 8'd0;
            remain_cnt <= 8'd0;
            byte_idx   <= 2'd0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            csum       <= 8'd0;
            in_ready   <= 1'b0;
            prog_mode  <= 1'b0;
            prog_addr  <= 8'd0;
            prog_data  <= '0;
            prog_we    <= 1'b0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    in_ready <= 1'b1;
                    // Anything other than SYNC is dropped while waiting for a frame
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state     <= ST_HDR_ADDR;
                        csum      <= 8'd0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_code  <= ERR_NONE;
                        prog_mode <= 1'b1;
                        busy      <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end
                end

                ST_HDR_ADDR: begin
                    if (accept) begin
                        addr_cnt <= in_data;
                        csum     <= csum_next;
                        state    <= ST_HDR_CNT;
                    end
                end

                ST_HDR_CNT: begin
                    if (accept) begin
                        csum <= csum_next;
                        if (range_bad) begin
                            state     <= ST_ERROR;
                            error     <= 1'b1;
                            err_code  <= ERR_RANGE;
                            prog_mode <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            remain_cnt <= in_data;
                            byte_idx   <= 2'd0;
                            state      <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
                        csum <= csum_next;
                        case (byte_idx)
                            2'd0: begin
                                b0_q     <= in_data;
                                byte_idx <= 2'd1;
                            end
                            2'd1: begin
                                b1_q     <= in_data;
                                byte_idx <= 2'd2;
                            end
                            default: begin
                                byte_idx <= 2'd0;
                                if (word_valid) begin
                                    prog_data <= word;
                                    prog_addr <= addr_cnt;
                                    prog_we   <= 1'b1;
                                    in_ready  <= 1'b0;
                                    state     <= ST_WRITE;
                                end else begin
                                    state     <= ST_ERROR;
                                    error     <= 1'b1;
                                    err_code  <= ERR_TRIT;
                                    prog_mode <= 1'b0;
                                    busy      <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                ST_WRITE: begin
                    // Single strobe cycle; the input is stalled so no byte is lost
                    prog_we    <= 1'b0;
                    in_ready   <= 1'b1;
                    addr_cnt   <= addr_cnt + 8'd1;
                    remain_cnt <= remain_cnt - 8'd1;
                    state      <= (remain_cnt == 8'd1) ? ST_CHK : ST_DATA;
                end

                ST_CHK: begin
                    if (accept) begin
                        prog_mode <= 1'b0;
                        busy      <= 1'b0;
                        if (csum_next == 8'd0) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state    <= ST_ERROR;
                            error    <= 1'b1;
                            err_code <= ERR_CHK;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
